// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the write responder and its address helper.
// Holds the burst/response encodings, the write-channel FSM state type and a
// helper that tells whether a WRAP burst length is legal.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_t;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_legal(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst address stepper.
// Given the current beat address and the burst attributes it returns the
// address of the following beat, and flags whether the burst length is legal
// for a WRAP burst. Shared between the write and (future) read responders.
//
// Ports:
//   addr_i      current beat byte address
//   len_i       beats minus one
//   size_i      log2 bytes per beat
//   burst_i     burst type
//   next_addr_o byte address of the next beat
//   wrap_ok_o   1 when len_i is a legal WRAP length
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0]  addr_i,
  input  logic [3:0]   len_i,
  input  logic [2:0]   size_i,
  input  burst_type_t  burst_i,
  output logic [31:0]  next_addr_o,
  output logic         wrap_ok_o
);

  logic [31:0] bytes;
  logic [31:0] total;
  logic [31:0] lower;
  logic [31:0] incr;

  always_comb begin
    bytes     = 32'd1 << size_i;
    total     = bytes * ({28'd0, len_i} + 32'd1);
    // Lower wrap boundary: the start address aligned down to the whole
    // wrap window. Only meaningful when total is a power of two.
    lower     = addr_i & ~(total - 32'd1);
    incr      = addr_i + bytes;
    wrap_ok_o = wrap_len_legal(len_i);

    case (burst_i)
      FIXED:   next_addr_o = addr_i;
      INCR:    next_addr_o = incr;
      WRAP:    next_addr_o = (incr == (lower + total)) ? lower : incr;
      default: next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// AXI3 write-channel responder backed by a word-addressed memory.
// Accepts one burst at a time on AW, writes the W beats into memory honouring
// byte strobes, then returns a B response carrying the burst's error status.
// A registered sideband port lets a bench peek at any memory word.
//
// Ports:
//   aclk_i / arst_ni        clock, asynchronous active-low reset
//   aw*_i, awready_o        write address channel
//   w*_i,  wready_o         write data channel
//   bid_o, bresp_o, bvalid_o, bready_i   write response channel
//   dbg_addr_i, dbg_rdata_o debug word index, registered read data
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | awready high, waiting for a write address
// ST_DATA | wready high, accepting beats until count == len
// ST_RESP | bvalid high, holding bid/bresp until bready
module axi_wr_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         aclk_i,
  input  logic                         arst_ni,
  input  logic [ID_W-1:0]              awid_i,
  input  logic [31:0]                  awaddr_i,
  input  logic [3:0]                   awlen_i,
  input  logic [2:0]                   awsize_i,
  input  burst_type_t                  awburst_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [ID_W-1:0]              wid_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W/8-1:0]          wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [ID_W-1:0]              bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]            dbg_rdata_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  wr_state_t   state_q, state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  burst_type_t burst_q, burst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        slv_q, slv_d;
  logic        dec_q, dec_d;
  resp_t       bresp_q, bresp_d;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [31:0]      next_addr;
  logic             wrap_ok;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             last_beat;
  logic             bad_burst;
  logic             mem_we;
  logic             unused_idx_bits;

  axi_burst_addr u_burst_addr (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .wrap_ok_o   (wrap_ok)
  );

  assign word_idx        = addr_q >> OFF_W;
  assign mem_idx         = word_idx[IDX_W-1:0];
  assign unused_idx_bits = ^word_idx[31:IDX_W];
  assign in_range        = (word_idx < 32'(MEM_DEPTH));
  assign last_beat       = (cnt_q == len_q);

  // Attributes are latched at AW time, so this is constant for the whole
  // burst; a bad burst reports SLVERR and never touches memory.
  assign bad_burst = (size_q > 3'(OFF_W)) || (burst_q == RSVD) ||
                     ((burst_q == WRAP) && !wrap_ok);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    slv_d   = slv_q;
    dec_d   = dec_q;
    bresp_d = bresp_q;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // W is never accepted here, even if it arrives with AW.
        if (awvalid_i && awready_q) begin
          id_d    = awid_i;
          addr_d  = awaddr_i;
          len_d   = awlen_i;
          size_d  = awsize_i;
          burst_d = awburst_i;
          cnt_d   = 4'd0;
          slv_d   = 1'b0;
          dec_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wvalid_i && wready_q) begin
          mem_we = !bad_burst && in_range;
          slv_d  = slv_q | bad_burst | (wid_i != id_q) | (wlast_i != last_beat);
          dec_d  = dec_q | !in_range;
          addr_d = next_addr;
          cnt_d  = cnt_q + 4'd1;
          // Burst length follows awlen; wlast only feeds the error flag.
          if (last_beat) begin
            state_d = ST_RESP;
            bresp_d = dec_d ? DECERR : (slv_d ? SLVERR : OKAY);
          end
        end
      end
      ST_RESP: begin
        if (bvalid_q && bready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, which keeps them
  // low in reset and makes awready rise only after the B handshake edge.
  assign awready_d = (state_d == ST_IDLE);
  assign wready_d  = (state_d == ST_DATA);
  assign bvalid_d  = (state_d == ST_RESP);

  always_ff @(posedge aclk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= FIXED;
      cnt_q     <= '0;
      slv_q     <= 1'b0;
      dec_q     <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      slv_q     <= slv_d;
      dec_q     <= dec_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge aclk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Reads the pre-write value when a beat targets the same word this cycle.
  always_ff @(posedge aclk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= mem_q[dbg_addr_i];
    end
  end

  assign awready_o   = awready_q;
  assign wready_o    = wready_q;
  assign bvalid_o    = bvalid_q;
  assign bid_o       = id_q;
  assign bresp_o     = bresp_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
module tb_axi_wr_slave_mem;
  import axi_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_DEPTH = 1024;

  logic              aclk = 1'b0;
  logic              arst_n = 1'b0;
  logic [ID_W-1:0]   awid = '0;
  logic [31:0]       awaddr = '0;
  logic [3:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  burst_type_t       awburst = INCR;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [ID_W-1:0]   wid = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [9:0]        dbg_addr = '0;
  logic [DATA_W-1:0] dbg_rdata;

  axi_wr_slave_mem #(.DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .aclk_i(aclk), .arst_ni(arst_n),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg_rdata)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    burst_type_t       burst;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [3:0]        id;
    logic [3:0][31:0]  data;
    logic [3:0][3:0]   strb;
    logic [3:0]        bad_wid_beat;  // 15 = none
    logic [1:0]        wlast_mode;    // 0 normal, 1 early on beat 0, 2 missing on final
    logic [3:0]        bdelay;
    logic [1:0]        exp_resp;
    logic [2:0]        n_chk;
    logic [3:0][9:0]   chk_idx;
    logic [3:0][31:0]  chk_val;
  } vec_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct packed {
    logic [9:0]  idx;
    logic [31:0] val;
  } mchk_t;

  bexp_t bq[$];
  mchk_t mq[$];
  vec_t  vecs[12];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic vec_t mk(input burst_type_t b, input logic [31:0] a, input logic [3:0] l,
                              input logic [2:0] s, input logic [3:0] id,
                              input logic [31:0] base, input resp_t r);
    vec_t v = '0;
    v.burst = b; v.addr = a; v.len = l; v.size = s; v.id = id;
    for (int i = 0; i < 4; i++) begin
      v.data[i] = base + 32'(i);
      v.strb[i] = 4'hF;
    end
    v.bad_wid_beat = 4'hF;
    v.exp_resp = r;
    return v;
  endfunction

  function automatic vec_t chk(input vec_t v, input logic [9:0] idx, input logic [31:0] val);
    vec_t o = v;
    o.chk_idx[o.n_chk] = idx;
    o.chk_val[o.n_chk] = val;
    o.n_chk = o.n_chk + 3'd1;
    return o;
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input burst_type_t b);
    int n = 0;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = b; awvalid = 1'b1;
    while (!awready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!awready) timeout("aw_handshake");
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    @(negedge aclk);
    wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!wready) timeout("w_handshake");
    @(posedge aclk);
    #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_b(input int delay);
    int n = 0;
    bexp_t e;
    @(negedge aclk);
    while (!bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!bvalid) timeout("b_handshake");
    repeat (delay) @(negedge aclk);
    bready = 1'b1;
    if (bq.size() == 0) begin
      timeout("b_scoreboard_empty");
    end else begin
      e = bq.pop_front();
      check("b_id", 64'(bid), 64'(e.id));
      check("b_resp", 64'(bresp), 64'(e.resp));
    end
    @(posedge aclk);
    #1;
    bready = 1'b0;
    check("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic drain_mem();
    mchk_t c;
    while (mq.size() > 0) begin
      c = mq.pop_front();
      @(negedge aclk);
      dbg_addr = c.idx;
      @(posedge aclk);
      #1;
      check($sformatf("mem[%0h]", c.idx), 64'(dbg_rdata), 64'(c.val));
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic lst;
    bq.push_back('{id: v.id, resp: v.exp_resp});
    for (int k = 0; k < int'(v.n_chk); k++) mq.push_back('{idx: v.chk_idx[k], val: v.chk_val[k]});
    send_aw(v.id, v.addr, v.len, v.size, v.burst);
    check("aw_to_w", {awready, wready}, 2'b01);
    for (int i = 0; i <= int'(v.len); i++) begin
      lst = (i == int'(v.len));
      if (v.wlast_mode == 2'd1 && i == 0) lst = 1'b1;
      if (v.wlast_mode == 2'd2 && lst) lst = 1'b0;
      send_w((i == int'(v.bad_wid_beat)) ? ~v.id : v.id, v.data[i], v.strb[i], lst);
    end
    check("b_latency", {bvalid, wready}, 2'b10);
    wait_b(int'(v.bdelay));
    drain_mem();
  endtask

  initial begin
    vec_t v;

    v = mk(INCR, 32'h10, 4'd3, 3'd2, 4'd5, 32'hA0, OKAY);
    v = chk(v, 10'd4, 32'hA0); v = chk(v, 10'd5, 32'hA1);
    v = chk(v, 10'd6, 32'hA2); v = chk(v, 10'd7, 32'hA3);
    vecs[0] = v;
    v = mk(WRAP, 32'h38, 4'd3, 3'd2, 4'd2, 32'hB0, OKAY);
    v = chk(v, 10'hE, 32'hB0); v = chk(v, 10'hF, 32'hB1);
    v = chk(v, 10'hC, 32'hB2); v = chk(v, 10'hD, 32'hB3);
    vecs[1] = v;
    v = mk(INCR, 32'h20, 4'd0, 3'd2, 4'd3, 32'h0, OKAY);
    vecs[2] = chk(v, 10'd8, 32'h0);
    v = mk(FIXED, 32'h20, 4'd2, 3'd2, 4'd3, 32'h0, OKAY);
    v.data[0] = 32'h11; v.data[1] = 32'h2200; v.data[2] = 32'h330000;
    v.strb[0] = 4'h1;   v.strb[1] = 4'h2;     v.strb[2] = 4'h4;
    vecs[3] = chk(v, 10'd8, 32'h00332211);
    v = mk(INCR, 32'hFFC, 4'd1, 3'd2, 4'd7, 32'hC0, DECERR);
    vecs[4] = chk(v, 10'd1023, 32'hC0);
    v = mk(INCR, 32'h40, 4'd2, 3'd2, 4'd1, 32'h5, OKAY);
    v = chk(v, 10'h10, 32'h5); v = chk(v, 10'h11, 32'h6);
    vecs[5] = chk(v, 10'h12, 32'h7);
    v = mk(WRAP, 32'h40, 4'd2, 3'd2, 4'd1, 32'hD0, SLVERR);
    v = chk(v, 10'h10, 32'h5); v = chk(v, 10'h11, 32'h6);
    vecs[6] = chk(v, 10'h12, 32'h7);
    v = mk(INCR, 32'h40, 4'd0, 3'd3, 4'd1, 32'hE0, SLVERR);
    vecs[7] = chk(v, 10'h10, 32'h5);
    v = mk(INCR, 32'h50, 4'd1, 3'd2, 4'd6, 32'h60, SLVERR);
    v.wlast_mode = 2'd2;
    v = chk(v, 10'h14, 32'h60);
    vecs[8] = chk(v, 10'h15, 32'h61);
    v = mk(INCR, 32'h58, 4'd1, 3'd2, 4'd6, 32'h70, SLVERR);
    v.wlast_mode = 2'd1; v.bdelay = 4'd2;
    v = chk(v, 10'h16, 32'h70);
    vecs[9] = chk(v, 10'h17, 32'h71);
    vecs[10] = mk(RSVD, 32'h60, 4'd0, 3'd2, 4'd2, 32'h80, SLVERR);
    v = mk(WRAP, 32'h6C, 4'd1, 3'd2, 4'd4, 32'h90, OKAY);
    v = chk(v, 10'h1B, 32'h90);
    vecs[11] = chk(v, 10'h1A, 32'h91);

    #12;
    check("reset_outputs", {awready, wready, bvalid, bid, bresp, dbg_rdata}, 64'd0);
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("idle_awready", {awready, wready, bvalid}, 3'b100);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // AW and W offered together, wid error on beat 1, B held off for 5 cycles.
    @(negedge aclk);
    wid = 4'd9; wdata = 32'hE0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    bq.push_back('{id: 4'd9, resp: SLVERR});
    mq.push_back('{idx: 10'h20, val: 32'hE0});
    mq.push_back('{idx: 10'h21, val: 32'hE1});
    send_aw(4'd9, 32'h80, 4'd1, 3'd2, INCR);
    check("aw_only_accepted", {awready, wready}, 2'b01);
    send_w(4'd9, 32'hE0, 4'hF, 1'b0);
    send_w(4'd4, 32'hE1, 4'hF, 1'b1);
    awaddr = 32'h200; awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("b_hold", {bvalid, bid, bresp, awready}, {1'b1, 4'd9, 2'b10, 1'b0});
    end
    @(negedge aclk);
    bready = 1'b1;
    check("b_hs_cycle_awready", 64'(awready), 64'd0);
    begin
      bexp_t e;
      e = bq.pop_front();
      check("b_id", 64'(bid), 64'(e.id));
      check("b_resp", 64'(bresp), 64'(e.resp));
    end
    @(posedge aclk);
    #1;
    bready = 1'b0;
    awvalid = 1'b0;
    check("awready_after_b", {awready, bvalid, wready}, 3'b100);
    drain_mem();

    // Reset in the middle of a 4-beat burst.
    @(negedge aclk);
    dbg_addr = 10'd4;
    send_aw(4'd1, 32'h100, 4'd3, 3'd2, INCR);
    send_w(4'd1, 32'hF0, 4'hF, 1'b0);
    send_w(4'd1, 32'hF1, 4'hF, 1'b0);
    arst_n = 1'b0;
    #1;
    check("reset_mid_burst", {awready, wready, bvalid, bid, bresp, dbg_rdata}, 64'd0);
    @(negedge aclk);
    arst_n = 1'b1;
    mq.push_back('{idx: 10'h40, val: 32'hF0});
    mq.push_back('{idx: 10'h41, val: 32'hF1});
    drain_mem();
    v = mk(INCR, 32'h100, 4'd3, 3'd2, 4'd1, 32'h1F0, OKAY);
    v = chk(v, 10'h40, 32'h1F0); v = chk(v, 10'h41, 32'h1F1);
    v = chk(v, 10'h42, 32'h1F2); v = chk(v, 10'h43, 32'h1F3);
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
AXI3 write-channel responder, the slave end of the write half of the team's AXI interface (AW, W and B channels).
- Accepts one write burst at a time and stores data into an internal word-addressed memory.
- Returns the B response with error checking.
- Provides a sideband debug read port so benches can inspect memory contents.

Parameters:
DATA_W, 32, data bus width in bits (32 or 64)
ID_W, 4, transaction ID width
MEM_DEPTH, 1024, memory depth in DATA_W words; byte base address is 0

Ports:
aclk  in  1  clock, all logic on rising edge
arst  in  1  reset, asynchronous assert, active-low
awid  in  ID_W  write address ID
awaddr  in  32  burst start byte address
awlen  in  4  beats minus one
awsize  in  3  log2 bytes per beat
awburst  in  burst_type_t  FIXED/INCR/WRAP/RSVD
awvalid  in  1  address valid
awready  out  1  address accepted
wid  in  ID_W  write data ID
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte-lane enables
wlast  in  1  last beat marker
wvalid  in  1  data valid
wready  out  1  data accepted
bid  out  ID_W  response ID (= latched awid)
bresp  out  2  OKAY/EXOKAY/SLVERR/DECERR
bvalid  out  1  response valid
bready  in  1  response accepted
dbg_addr  in  $clog2(MEM_DEPTH)  debug word index
dbg_rdata  out  DATA_W  memory word at dbg_addr, registered

Behaviour:
- Reset (arst low, async): FSM to IDLE; awready, wready, bvalid, bid, bresp and dbg_rdata go to 0. Memory contents are not reset. Reset mid-burst abandons the burst; beats already written remain.
- FSM IDLE:
  - awready=1; wready=0.
  - On awvalid&&awready, latch id, addr, len, size and burst; clear beat counter and error flags; go to DATA.
  - Simultaneous awvalid/wvalid in IDLE accepts only AW.
- FSM DATA:
  - wready=1; awready=0.
  - Each W handshake writes the bytes enabled by wstrb into word addr>>log2(DATA_W/8), then advances the address and beat counter.
  - On the beat where count==len, go to RESP. Burst length is governed by len only, not wlast.
- FSM RESP:
  - bvalid=1; bid and bresp are held stable until bready.
  - On handshake, go to IDLE. awready rises the cycle after the B handshake, never in the same cycle.
- Latency: AW accepted at cycle 0, first W beat accepted at cycle 1 at the earliest, bvalid asserted the cycle after the last W handshake.
- Next-address rules, with bytes=1<<size:
  - FIXED: address unchanged.
  - INCR: addr+bytes, modulo 2^32.
  - WRAP: total=bytes*(len+1); lower=addr & ~(total-1); next=addr+bytes; if next==lower+total then next=lower.
- Error rules (flags are sticky per burst):
  - wid != latched id -> SLVERR; data still written.
  - wlast high before the final beat, or low on the final beat -> SLVERR.
  - size > log2(DATA_W/8), burst RSVD, or WRAP with len not in {1,3,7,15} -> SLVERR, and all writes of the burst are suppressed.
  - Word index >= MEM_DEPTH -> that beat is not written; DECERR.
  - bresp priority: DECERR > SLVERR > OKAY. EXOKAY is never produced.
- Debug port: dbg_rdata updates one cycle after dbg_addr. When a write and a debug read hit the same word in the same cycle, dbg_rdata returns the old data.

Decomposition:
- Shared package axi_pkg holds:
  - burst_type_t: FIXED=2'b00, INCR=2'b01, WRAP=2'b10, RSVD=2'b11.
  - resp_t: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state enum.
- One sub-module, axi_burst_addr: combinational next-address and WRAP-legality calculation, reused by the future read responder.

Test Plan:
- INCR, awid=5, awaddr=0x10, len=3, size=2, wstrb=F, data A0..A3 -> words 4..7 = A0..A3; bid=5, bresp=OKAY.
- WRAP, awaddr=0x38, len=3, size=2, data B0..B3 -> words 0xE=B0, 0xF=B1, 0xC=B2, 0xD=B3; OKAY.
- FIXED, awaddr=0x20, len=2, wstrb 1/2/4, data 0x11/0x2200/0x330000 -> word 8 = 0x00332211; OKAY.
- awaddr=0xFFC, len=1, MEM_DEPTH=1024 -> word 1023 written, second beat dropped; bresp=DECERR.
- wid mismatch on beat 1 with bready held low 5 cycles -> data written; bvalid, bid and bresp=SLVERR held stable; awready stays 0 until the cycle after the handshake.
- arst low after 2 of 4 beats -> all outputs 0 immediately; words from beats 0-1 kept; next INCR burst completes with OKAY.
